// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester/consumer bundle for the round-robin option-mux arbiter
//   req/opt    per-requester request bits and packed option words (slot i = requester i)
//   ack        one-hot beat-accepted strobe back to the granted requester
//   sel        current mux select (granted index)
//   out_data   opt[sel]; out_valid/out_ready downstream handshake
//   busy       arbiter is holding a grant
//   master modport = arbiter side, slave modport = sources/consumer side
interface mux_rr_arbiter_if #(
    parameter int WIDTH_IN  = 2,
    parameter int WIDTH_OP  = 2**WIDTH_IN,
    parameter int WIDTH_BUS = 3
);
    logic [WIDTH_OP-1:0]                req;
    logic [WIDTH_OP-1:0][WIDTH_BUS-1:0] opt;
    logic [WIDTH_OP-1:0]                ack;
    logic [WIDTH_IN-1:0]                sel;
    logic [WIDTH_BUS-1:0]               out_data;
    logic                               out_valid;
    logic                               out_ready;
    logic                               busy;
    modport master (input req, opt, out_ready, output ack, sel, out_data, out_valid, busy);
    modport slave  (output req, opt, out_ready, input ack, sel, out_data, out_valid, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one output bus among WIDTH_OP requesters
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_rr_arbiter_if.master (req, opt, out_ready in; ack, sel, out_data, out_valid, busy out)
module mux_rr_arbiter #(
    parameter int WIDTH_IN  = 2,
    parameter int WIDTH_OP  = 2**WIDTH_IN,
    parameter int WIDTH_BUS = 3,
    parameter int MAX_HOLD  = 4
)(
    input logic              clk,
    input logic              rst_n,
    mux_rr_arbiter_if.master bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t              state, state_nx;
    logic [WIDTH_IN-1:0] last, sel, win, idx;
    logic [HW-1:0]       hold_cnt;
    logic [WIDTH_BUS-1:0] data_mux;
    logic                found, xfer;
    // Scan last+1 .. last+WIDTH_OP; the select width wraps the index modulo WIDTH_OP.
    always_comb begin
        win   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= WIDTH_OP; k++) begin
            idx = last + WIDTH_IN'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    assign data_mux      = bus.opt[sel];
    assign bus.out_data  = data_mux;
    assign bus.sel       = sel;
    assign bus.busy      = state == GRANT;
    assign bus.out_valid = state == GRANT && bus.req[sel];
    assign xfer          = bus.out_valid && bus.out_ready;
    assign bus.ack       = xfer ? (WIDTH_OP'(1) << sel) : '0;
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = found ? GRANT : IDLE;
        else if (!bus.req[sel] || (xfer && hold_cnt == HW'(MAX_HOLD - 1)))
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= '1;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                sel      <= win;
                last     <= win;
                hold_cnt <= '0;
            end else if (xfer) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of two arbiter builds (MAX_HOLD 4 and 1) against a grant-level model
module tb_mux_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [3:0]      req;
    logic [3:0][2:0] opt;
    logic            ready;
    mux_rr_arbiter_if #(.WIDTH_IN(2), .WIDTH_OP(4), .WIDTH_BUS(3)) b0 ();
    mux_rr_arbiter_if #(.WIDTH_IN(2), .WIDTH_OP(4), .WIDTH_BUS(3)) b1 ();
    assign b0.req = req;
    assign b0.opt = opt;
    assign b0.out_ready = ready;
    assign b1.req = req;
    assign b1.opt = opt;
    assign b1.out_ready = ready;
    mux_rr_arbiter #(.WIDTH_IN(2), .WIDTH_OP(4), .WIDTH_BUS(3), .MAX_HOLD(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_rr_arbiter #(.WIDTH_IN(2), .WIDTH_OP(4), .WIDTH_BUS(3), .MAX_HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    int vecs = 0;
    int errs = 0;
    // Grant-level model: who owns the bus, how many beats it has moved, who was granted last.
    bit m_busy [2];
    int m_sel [2];
    int m_last [2];
    int m_beats [2];
    int hold_of [2] = '{4, 1};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_sel[d] = 0;
            m_last[d] = 3;
            m_beats[d] = 0;
        end
    endtask
    task automatic check_dut(input int d, input logic busy, input logic [1:0] sel, input logic valid,
                             input logic [2:0] data, input logic [3:0] ack);
        logic v;
        v = m_busy[d] && req[m_sel[d]];
        chk($sformatf("d%0d busy", d), busy, m_busy[d]);
        chk($sformatf("d%0d sel", d), sel, m_sel[d]);
        chk($sformatf("d%0d out_valid", d), valid, v);
        chk($sformatf("d%0d out_data", d), data, opt[m_sel[d]]);
        chk($sformatf("d%0d ack", d), ack, (v && ready) ? (32'd1 << m_sel[d]) : 32'd0);
    endtask
    task automatic check_now();
        check_dut(0, b0.busy, b0.sel, b0.out_valid, b0.out_data, b0.ack);
        check_dut(1, b1.busy, b1.sel, b1.out_valid, b1.out_data, b1.ack);
        if (m_busy[0]) chk("d0 hold_cnt", u0.hold_cnt, m_beats[0]);
    endtask
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!m_busy[d]) begin
                for (int k = 1; k <= 4; k++) begin
                    if (!m_busy[d] && req[(m_last[d] + k) % 4]) begin
                        m_sel[d] = (m_last[d] + k) % 4;
                        m_last[d] = m_sel[d];
                        m_beats[d] = 0;
                        m_busy[d] = 1;
                    end
                end
            end else if (!req[m_sel[d]]) begin
                m_busy[d] = 0;
            end else if (ready) begin
                m_beats[d]++;
                if (m_beats[d] == hold_of[d]) m_busy[d] = 0;
            end
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_now();
            @(posedge clk);
            if (rst_n) model_step();
            #1;
        end
    endtask
    // Pulls reset mid-cycle so the asynchronous clear is visible before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        req = '0;
        ready = 1'b0;
        opt = {3'b011, 3'b101, 3'b100, 3'b110};
        model_reset();
        do_reset();
        req = 4'b0001;
        ready = 1'b1;
        cyc(1);
        chk("s1 busy", b0.busy, 1);
        chk("s1 data", b0.out_data, 3'b110);
        cyc(12);
        do_reset();
        req = 4'b1111;
        cyc(26);
        do_reset();
        req = 4'b0100;
        ready = 1'b0;
        cyc(6);
        chk("s3 stalled data", b0.out_data, 3'b101);
        ready = 1'b1;
        cyc(6);
        do_reset();
        req = 4'b0010;
        cyc(3);
        req = 4'b0000;
        cyc(1);
        chk("s4 last", u0.last, 1);
        req = 4'b0011;
        cyc(12);
        do_reset();
        req = 4'b1111;
        cyc(3);
        do_reset();
        req = 4'b1000;
        cyc(1);
        chk("s5 data", b0.out_data, 3'b011);
        cyc(7);
        do_reset();
        req = 4'b0011;
        cyc(12);
        do_reset();
        repeat (400) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            ready = $urandom_range(3) != 0;
            if ($urandom_range(7) == 0) opt = 12'($urandom);
            if ($urandom_range(99) == 0) do_reset();
            cyc(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one WIDTH_BUS-bit output bus among WIDTH_OP requesters by sequencing the select of a ternary option mux. Each requester presents a word on its `opt` slot and raises `req`. The arbiter grants one requester at a time and forwards its words over a valid/ready output port. It bounds each grant to MAX_HOLD beats for fairness. The block sits between the option sources and a single downstream consumer, replacing a free-running testbench-driven select.

## Interface
- WIDTH_IN, 2, select width; WIDTH_OP = 2**WIDTH_IN
- WIDTH_OP, 4, number of requesters / mux options
- WIDTH_BUS, 3, data word width
- MAX_HOLD, 4, max beats per grant (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  WIDTH_OP  per-requester request, bit i = requester i
- opt  in  [WIDTH_OP-1:0][WIDTH_BUS-1:0]  packed option words, slot i = requester i
- ack  out  WIDTH_OP  one-hot beat-accepted strobe to the granted requester
- sel  out  WIDTH_IN  current mux select (granted index)
- out_data  out  WIDTH_BUS  opt[sel]
- out_valid  out  1  beat available downstream
- out_ready  in  1  downstream accepts beat
- busy  out  1  high in GRANT state

## Operation
- FSM states: IDLE, GRANT. A registered pointer `last` holds the most recently granted index.
- IDLE, any req set:
  - search indices last+1, last+2, … mod WIDTH_OP; the first set bit wins.
  - register winner into sel and last; clear hold_cnt; go GRANT.
- IDLE, req == 0: stay IDLE.
- GRANT:
  - out_valid = req[sel]; out_data = opt[sel] (combinational mux on registered sel).
  - Transfer = out_valid && out_ready. On a transfer: ack[sel]=1 that cycle, hold_cnt++.
- GRANT exits to IDLE on any of these:
  - req[sel]==0 (no transfer that cycle);
  - a transfer with hold_cnt == MAX_HOLD-1.
  - Otherwise stay GRANT.
- Requester contract: opt[i] and req[i] stay stable from assertion until the ack[i] cycle.
  - If a requester drops req early, out_valid falls with it and the grant is released. This is tolerated, not an error.
- hold_cnt width is $clog2(MAX_HOLD+1); it never wraps within a grant.
- sel holds its last value in IDLE. out_data still shows opt[sel], but out_valid=0.
- ack is never asserted in IDLE. At most one ack bit is set per cycle.

## Timing
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, last=WIDTH_OP-1 (so requester 0 has first priority), sel=0, hold_cnt=0;
  - therefore out_valid=0, ack=0, busy=0.
- Reset asserted mid-grant forces IDLE immediately. The in-flight beat is not acked.
- Grant latency: req sampled in IDLE at edge N → busy=1, sel valid, out_valid=1 from cycle N+1.
- Throughput: one beat per cycle while granted and out_ready=1.
- Each grant is followed by exactly one IDLE bubble cycle before the next grant, including a re-grant of the same requester.
- out_ready low stalls the grant indefinitely. hold_cnt does not advance, and out_data and out_valid stay stable.
- Simultaneous requests: strictly round-robin from last+1. A sole requester is re-granted after the bubble.
- out_valid and ack are combinational from req and out_ready within GRANT. There is no output register.

## Test plan
- Setup for all scenarios: opt = {3'b011,3'b101,3'b100,3'b110}, so opt[0]=110, opt[1]=100, opt[2]=101, opt[3]=011.
1. Reset, then req=4'b0001 with out_ready=1 held.
   - busy and out_valid rise 1 cycle later with sel=0, out_data=110.
   - ack=0001 for 4 cycles, then one IDLE bubble, then re-grant of 0.
2. req=4'b1111 held, out_ready=1.
   - Grant order 0,1,2,3,0; out_data is 110, 100, 101, 011, 110.
   - Each grant lasts 4 beats, separated by 1 bubble.
3. req=4'b0100 granted, out_ready=0 for 5 cycles, then 1.
   - out_valid=1 and out_data=101 stay stable, ack=0, hold_cnt stays 0.
   - Then 4 acks follow.
4. req=4'b0010 granted; drop req[1] after 2 acked beats.
   - out_valid falls the same cycle; state returns to IDLE next edge; last=1.
   - A following req=4'b0011 grants 0 before 1 (search starts at 2).
5. rst_n pulsed low mid-grant at hold_cnt=2.
   - Outputs go to reset values asynchronously.
   - After release with req=4'b1000, the grant goes to 3 (only requester), out_data=011.
6. MAX_HOLD=1 build, req=4'b0011.
   - Alternating grants 0,1,0,1, one beat each, with ack and the bubble pattern verified.
